// File: rtl/irq_pending_latch.sv
// Interrupt pending latch: captures request lines into a pending register,
// presents masked pending bits to a downstream priority encoder and runs a
// small IDLE/ASSERT/HOLDOFF handshake with ack, ack_err and timeout pulses.
// Optional build macro: IRQ_EDGE_DETECT_EN (rising-edge capture instead of
// level capture).
module irq_pending_latch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] irq_in,
    input  logic [6:0] mask,
    output logic [7:0] pend_out,
    output logic       irq_valid,
    input  logic       ack,
    input  logic [3:0] ack_code,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned NLINES = 7;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NLINES-1:0]  pending;
    logic [NLINES-1:0]  pending_next;
    logic [NLINES-1:0]  visible;
    logic [NLINES-1:0]  set_vec;
    logic [NLINES-1:0]  clr_vec;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [7:0]         code_dec;
    logic               code_ok;
    logic               ack_ok;
    logic               ack_err_next;
    logic               timeout_next;

    // Encoder-facing view; bit 7 is outside the code space and always zero
    assign visible   = pending & mask;
    assign pend_out  = {1'b0, visible};
    assign irq_valid = (state == ASSERT);

    // Decode ack_code: code c selects line c-1, only codes 1..7 are meaningful
    assign code_dec = 8'(8'd1 << ack_code[2:0]);
    assign code_ok  = ~ack_code[3] & (|ack_code[2:0]);
    assign ack_ok   = ack && (state == ASSERT) && code_ok
                      && (|(code_dec[7:1] & visible));
    assign clr_vec  = ack_ok ? code_dec[7:1] : '0;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NLINES-1:0] prev;

    // Previous sample of the request lines for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= irq_in;
        end
    end

    assign set_vec = irq_in & ~prev;
`else
    assign set_vec = irq_in;
`endif

    // A set on the same cycle as a clear wins, so the line stays pending
    assign pending_next = (pending & ~clr_vec) | set_vec;

    // Next-state, counter and pulse decisions
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ack_err_next = ack && !ack_ok;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (|visible) begin
                    state_next = ASSERT;
                    cnt_next   = '0;
                end
            end
            ASSERT: begin
                if (ack_ok) begin
                    state_next = HOLDOFF;
                    cnt_next   = '0;
                end else if (!(|visible)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HOLDOFF: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, pending, counter and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            cnt     <= '0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            cnt     <= cnt_next;
            ack_err <= ack_err_next;
            timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: a cycle model pushes expected
// outputs into a scoreboard queue, popped after each clock edge; directed
// scenarios add fixed expected values on top.
module tb_irq_pending_latch;

    localparam int T = 16;

    logic       clk;
    logic       rst;
    logic [6:0] irq_in;
    logic [6:0] mask;
    logic [7:0] pend_out;
    logic       irq_valid;
    logic       ack;
    logic [3:0] ack_code;
    logic       ack_err;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [6:0]  m_pend;
    logic [6:0]  m_prev;
    int          m_st;
    int          m_cnt;
    logic [10:0] exp_q[$];

    irq_pending_latch #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .pend_out  (pend_out),
        .irq_valid (irq_valid),
        .ack       (ack),
        .ack_code  (ack_code),
        .ack_err   (ack_err),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_prev = '0;
        m_st   = 0;
        m_cnt  = 0;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then compare
    task automatic step(input string tag, input logic [6:0] irq, input logic [6:0] msk,
                        input logic a, input logic [3:0] code);
        logic [6:0]  vis;
        logic [6:0]  setv;
        logic [6:0]  clrv;
        logic        ok;
        logic        nerr;
        logic        nto;
        int          ci;
        int          nst;
        logic [10:0] e;
        irq_in   = irq;
        mask     = msk;
        ack      = a;
        ack_code = code;
        vis  = m_pend & msk;
        ci   = int'(code) - 1;
        ok   = a && (m_st == 1) && (ci >= 0) && (ci <= 6) && vis[ci];
`ifdef IRQ_EDGE_DETECT_EN
        setv = irq & ~m_prev;
`else
        setv = irq;
`endif
        clrv = ok ? 7'(1 << ci) : 7'h00;
        nerr = a && !ok;
        nto  = 1'b0;
        nst  = m_st;
        case (m_st)
            0: if (vis != 0) begin nst = 1; m_cnt = 0; end
            1: begin
                if (ok) nst = 2;
                else if (vis == 0) nst = 0;
                else if (m_cnt == T - 1) begin nto = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end
            default: nst = 0;
        endcase
        m_pend = (m_pend & ~clrv) | setv;
        m_prev = irq;
        m_st   = nst;
        exp_q.push_back({1'b0, m_pend & msk, (m_st == 1), nerr, nto});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pend"},  32'(pend_out),  32'(e[10:3]));
            check({tag, "_valid"}, 32'(irq_valid), 32'(e[2]));
            check({tag, "_err"},   32'(ack_err),   32'(e[1]));
            check({tag, "_to"},    32'(timeout),   32'(e[0]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pend"},  32'(pend_out),  32'h0);
        check({tag, "_valid"}, 32'(irq_valid), 32'h0);
        check({tag, "_err"},   32'(ack_err),   32'h0);
        check({tag, "_to"},    32'(timeout),   32'h0);
    endtask

    // Single-pulse request on bit 2, serviced with code 3
    task automatic single_pulse_seq(input string tag);
        step({tag, "_req"}, 7'h04, 7'h7F, 1'b0, 4'd0);
        check({tag, "_pend04"}, 32'(pend_out), 32'h04);
        check({tag, "_v0"}, 32'(irq_valid), 32'h0);
        step({tag, "_asrt"}, 7'h00, 7'h7F, 1'b0, 4'd0);
        check({tag, "_v1"}, 32'(irq_valid), 32'h1);
        step({tag, "_ack"}, 7'h00, 7'h7F, 1'b1, 4'd3);
        check({tag, "_pend00"}, 32'(pend_out), 32'h00);
        check({tag, "_hold"}, 32'(irq_valid), 32'h0);
        step({tag, "_idle"}, 7'h00, 7'h7F, 1'b0, 4'd0);
        check({tag, "_idle_v"}, 32'(irq_valid), 32'h0);
        check({tag, "_idle_e"}, 32'(ack_err), 32'h0);
    endtask

    initial begin
        int to_cnt;
        int to_first;
        int to_second;
        int v_low;
        irq_in   = '0;
        mask     = '0;
        ack      = 1'b0;
        ack_code = '0;
        rst      = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_all_zero("por_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b0;

        // Basic single request
        single_pulse_seq("r31");

        // Two lines pending, service the higher one only
        step("r32_req", 7'h21, 7'h7F, 1'b0, 4'd0);
        check("r32_pend21", 32'(pend_out), 32'h21);
        step("r32_asrt", 7'h00, 7'h7F, 1'b0, 4'd0);
        step("r32_ack", 7'h00, 7'h7F, 1'b1, 4'd6);
        check("r32_pend01", 32'(pend_out), 32'h01);
        check("r32_hold", 32'(irq_valid), 32'h0);
        step("r32_idle", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r32_idle_v", 32'(irq_valid), 32'h0);
        step("r32_re", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r32_revalid", 32'(irq_valid), 32'h1);

        // Bad acks with bit 0 pending and bit 3 clear
        step("r33_c0", 7'h00, 7'h7F, 1'b1, 4'd0);
        check("r33_c0_err", 32'(ack_err), 32'h1);
        check("r33_c0_pend", 32'(pend_out), 32'h01);
        step("r33_gap", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r33_gap_err", 32'(ack_err), 32'h0);
        step("r33_c8", 7'h00, 7'h7F, 1'b1, 4'd8);
        check("r33_c8_err", 32'(ack_err), 32'h1);
        step("r33_c4", 7'h00, 7'h7F, 1'b1, 4'd4);
        check("r33_c4_err", 32'(ack_err), 32'h1);
        check("r33_c4_pend", 32'(pend_out), 32'h01);
        step("r33_clr", 7'h00, 7'h7F, 1'b1, 4'd1);
        check("r33_clr_err", 32'(ack_err), 32'h0);
        step("r33_hold_ack", 7'h00, 7'h7F, 1'b1, 4'd1);
        check("r33_hold_err", 32'(ack_err), 32'h1);
        step("r33_idle", 7'h00, 7'h7F, 1'b0, 4'd0);

        // New request on bit 1 in the same cycle its ack clears it
        step("r35_req", 7'h02, 7'h7F, 1'b0, 4'd0);
        step("r35_low", 7'h00, 7'h7F, 1'b0, 4'd0);
        step("r35_ack", 7'h02, 7'h7F, 1'b1, 4'd2);
        check("r35_keep", 32'(pend_out), 32'h02);
        step("r35_idle", 7'h00, 7'h7F, 1'b0, 4'd0);
        step("r35_asrt", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r35_asrt_v", 32'(irq_valid), 32'h1);
        step("r35_clr", 7'h00, 7'h7F, 1'b1, 4'd2);
        check("r35_clr_pend", 32'(pend_out), 32'h00);
        step("r35_end", 7'h00, 7'h7F, 1'b0, 4'd0);

        // Mask drop during ASSERT returns to IDLE; mask rise shows bit at once
        step("r24_req", 7'h10, 7'h7F, 1'b0, 4'd0);
        step("r24_asrt", 7'h00, 7'h7F, 1'b0, 4'd0);
        step("r24_drop", 7'h00, 7'h00, 1'b0, 4'd0);
        check("r24_drop_v", 32'(irq_valid), 32'h0);
        check("r24_drop_pend", 32'(pend_out), 32'h00);
        step("r24_hidden", 7'h00, 7'h00, 1'b0, 4'd0);
        mask = 7'h7F;
        #1;
        check("r23_rise", 32'(pend_out), 32'h10);
        step("r24_back", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r24_back_v", 32'(irq_valid), 32'h1);
        step("r24_clr", 7'h00, 7'h7F, 1'b1, 4'd5);
        step("r24_end", 7'h00, 7'h7F, 1'b0, 4'd0);

        // Timeout every T cycles of an unserviced ASSERT
        step("r34_req", 7'h01, 7'h7F, 1'b0, 4'd0);
        step("r34_a0", 7'h00, 7'h7F, 1'b0, 4'd0);
        to_cnt = 0; to_first = -1; to_second = -1; v_low = 0;
        for (int i = 1; i <= 34; i++) begin
            step("r34_run", 7'h00, 7'h7F, 1'b0, 4'd0);
            if (irq_valid !== 1'b1) v_low++;
            if (timeout === 1'b1) begin
                if (to_cnt == 0) to_first = i;
                else if (to_cnt == 1) to_second = i;
                to_cnt++;
            end
        end
        check("r34_count", 32'(to_cnt), 32'd2);
        check("r34_first", 32'(to_first), 32'd16);
        check("r34_second", 32'(to_second), 32'd32);
        check("r34_valid_held", 32'(v_low), 32'd0);
        step("r34_clr", 7'h00, 7'h7F, 1'b1, 4'd1);
        step("r34_end", 7'h00, 7'h7F, 1'b0, 4'd0);

        // Reset mid-ASSERT with three lines pending and an ack_err in flight
        step("r36_req", 7'h13, 7'h7F, 1'b0, 4'd0);
        step("r36_asrt", 7'h00, 7'h7F, 1'b0, 4'd0);
        step("r36_bad", 7'h00, 7'h7F, 1'b1, 4'd4);
        check("r36_pre_err", 32'(ack_err), 32'h1);
        ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("r36_async");
        @(posedge clk);
        #1;
        check_all_zero("r36_held");
        rst = 1'b0;
        model_reset();
        step("r36_after", 7'h00, 7'h7F, 1'b0, 4'd0);
        check("r36_discard", 32'(pend_out), 32'h00);
        check("r36_idle", 32'(irq_valid), 32'h0);
        single_pulse_seq("r36_rerun");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [6:0] rirq;
            logic [6:0] rmsk;
            logic       ra;
            logic [3:0] rc;
            rirq = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            rmsk = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h7F;
            ra   = ($urandom_range(0, 2) == 0);
            rc   = 4'($urandom_range(0, 8));
            step("rand", rirq, rmsk, ra, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
